// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_muldiv_ctrl                                                   |
// | Brief   : Iterative unsigned MUL/DIV sequencer beside the EX-stage ALU;    |
// |           optional early divide-by-zero exit via MULDIV_DIV0_EXP_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div0
);

  localparam logic [1:0]       c_st_idle = 2'd0;
  localparam logic [1:0]       c_st_calc = 2'd1;
  localparam logic [1:0]       c_st_done = 2'd2;
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(DATA_W - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_opnd;
  logic [2*DATA_W-1:0] r_acc;
  logic                w_accept;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W-1:0]   w_sub;
  logic                w_ge;
  logic [2*DATA_W-1:0] w_acc_step;
`ifdef MULDIV_DIV0_EXP_EN
  logic                r_div0;
  logic                w_div0_start;
  assign w_div0_start = op[1] && (in_1 == '0);
`endif

  assign w_accept = (r_state == c_st_idle) && start && !flush;

  // Shared accumulator: MUL keeps {product_hi, multiplier/product_lo};
  // DIV keeps {partial remainder, dividend shifting out / quotient shifting in}.
  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shift   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_ge      = w_shift[DATA_W] | (w_shift[DATA_W-1:0] >= r_opnd);
  assign w_sub     = w_shift[DATA_W-1:0] - r_opnd;
  assign w_acc_step = r_op[1]
      ? {(w_ge ? w_sub : w_shift[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge}
      : {w_mul_sum, r_acc[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (start && !flush) begin
`ifdef MULDIV_DIV0_EXP_EN
          w_next = w_div0_start ? c_st_done : c_st_calc;
`else
          w_next = c_st_calc;
`endif
        end
      end
      c_st_calc: begin
        if (flush)                w_next = c_st_idle;
        else if (r_cnt == c_last) w_next = c_st_done;
      end
      c_st_done: begin
        if (flush || !stall) w_next = c_st_idle;
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_opnd <= '0;
      r_acc  <= '0;
`ifdef MULDIV_DIV0_EXP_EN
      r_div0 <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_op   <= op;
      r_opnd <= op[1] ? in_1 : in_0;
      r_acc  <= {{DATA_W{1'b0}}, (op[1] ? in_0 : in_1)};
`ifdef MULDIV_DIV0_EXP_EN
      r_div0 <= w_div0_start;
`endif
    end else if (r_state == c_st_calc) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_step;
    end
  end

  // Outputs are gated by reset so they read zero during the reset cycle itself.
  always_comb begin
    stall_req = 1'b0;
    done      = 1'b0;
    result    = '0;
    div0      = 1'b0;
    if (reset) begin
      case (r_state)
        c_st_idle: stall_req = start && !flush;
        c_st_calc: stall_req = 1'b1;
        c_st_done: begin
          done   = 1'b1;
          result = r_op[0] ? r_acc[2*DATA_W-1:DATA_W] : r_acc[DATA_W-1:0];
`ifdef MULDIV_DIV0_EXP_EN
          if (r_div0) begin
            div0   = 1'b1;
            result = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ex_muldiv_ctrl                                                |
// | Brief   : Randomized bench for ex_muldiv_ctrl against a transaction model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] in_0 = '0;
  logic [W-1:0] in_1 = '0;
  logic         stall_req;
  logic         done;
  logic [W-1:0] result;
  logic         div0;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .start(start),
    .op(op), .in_0(in_0), .in_1(in_1),
    .stall_req(stall_req), .done(done), .result(result), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Transaction-level model: cycles of work left, and the pending answer.
  int           m_busy = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  bit           m_div0 = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_div0 <= 1'b0;
    end else if (m_done) begin
      if (flush || !stall) m_done <= 1'b0;
    end else if (m_busy > 0) begin
      if (flush) m_busy <= 0;
      else if (m_busy == 1) begin
        m_busy <= 0;
        m_done <= 1'b1;
      end else m_busy <= m_busy - 1;
    end else if (start && !flush) begin
`ifdef MULDIV_DIV0_EXP_EN
      if (op[1] && in_1 == 0) begin
        m_done <= 1'b1;
        m_res  <= '0;
        m_div0 <= 1'b1;
      end else begin
        m_busy <= W;
        m_res  <= ref_result(op, in_0, in_1);
        m_div0 <= 1'b0;
      end
`else
      m_busy <= W;
      m_res  <= ref_result(op, in_0, in_1);
      m_div0 <= 1'b0;
`endif
    end
  end

  always @(negedge clk) begin : p_cmp
    logic         e_sr;
    logic         e_done;
    logic         e_div0;
    logic [W-1:0] e_res;
    e_sr = 1'b0; e_done = 1'b0; e_div0 = 1'b0; e_res = '0;
    if (reset) begin
      if (m_done) begin
        e_done = 1'b1;
        e_res  = m_res;
        e_div0 = m_div0;
      end else if (m_busy > 0) e_sr = 1'b1;
      else e_sr = start && !flush;
    end
    chk("cyc_stall_req", stall_req, e_sr);
    chk("cyc_done", done, e_done);
    chk("cyc_result", result, e_res);
    chk("cyc_div0", div0, e_div0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    step();
    start = 1'b1; op = o; in_0 = a; in_1 = b;
    #1 chk("stall_req_at_T", stall_req, 1'b1);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_chk(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input int exp_lat, input logic exp_div0);
    int lat;
    issue(o, a, b);
    wait_done(lat);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, result, exp_res);
    chk({name, "_div0"}, div0, exp_div0);
    step();
  endtask

  initial begin
    int guard;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    // Reset with start asserted: nothing may be requested.
    start = 1'b1;
    repeat (3) step();
    chk("rst_stall_req", stall_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 0);
    start = 1'b0;
    reset = 1'b1;
    step();

    run_chk("mulu_lo", 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 1'b0);
    run_chk("mulu_hi", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 1'b0);
    run_chk("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_chk("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_chk("divu_max_1", 2'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
`ifdef MULDIV_DIV0_EXP_EN
    run_chk("divu_5_0", 2'd2, 32'd5, 32'd0, 32'd0, 1, 1'b1);
    run_chk("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd0, 1, 1'b1);
`else
    run_chk("divu_5_0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 1'b0);
    run_chk("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 33, 1'b0);
`endif

    // Hold stall across DONE: result must stay put until the stall drops.
    begin
      int lat;
      stall = 1'b1;
      issue(2'd0, 32'd1234, 32'd5678);
      wait_done(lat);
      chk("hold_latency", lat, 33);
      chk("hold_result0", result, 32'h006A_E9BC);
      step();
      chk("hold_done1", done, 1'b1);
      chk("hold_result1", result, 32'h006A_E9BC);
      step();
      chk("hold_done2", done, 1'b1);
      chk("hold_result2", result, 32'h006A_E9BC);
      step();
      stall = 1'b0;
      chk("hold_done3", done, 1'b1);
      step();
      chk("hold_idle_done", done, 1'b0);
      chk("hold_idle_stall_req", stall_req, 1'b0);
    end

    // Flush mid-CALC, then a fresh op two cycles later.
    issue(2'd0, 32'd3, 32'd4);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stall_req", stall_req, 1'b0);
    chk("flush_done", done, 1'b0);
    run_chk("after_flush", 2'd2, 32'd1000, 32'd33, 32'd30, 33, 1'b0);

    // Reset mid-CALC with start held high.
    issue(2'd2, 32'd1000, 32'd3);
    repeat (19) step();
    reset = 1'b0;
    start = 1'b1; op = 2'd0; in_0 = 32'd9; in_1 = 32'd9;
    step();
    chk("midrst_stall_req", stall_req, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 0);
    step();
    reset = 1'b1;
    start = 1'b0;
    step();
    chk("postrst_stall_req", stall_req, 1'b0);
    chk("postrst_done", done, 1'b0);
    repeat (3) step();

    // Randomized traffic with stalls and occasional flushes.
    repeat (60) begin
      repeat ($urandom_range(0, 2)) step();
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); end
        1:       begin ra = $urandom; rb = $urandom; end
        2:       begin ra = $urandom; rb = '0; end
        default: begin ra = '1; rb = $urandom; end
      endcase
      step();
      start = 1'b1; op = ro; in_0 = ra; in_1 = rb;
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
      start = 1'b0;
      flush = 1'b0;
      guard = 0;
      while ((m_busy > 0 || m_done) && guard < 100) begin
        stall = ($urandom_range(0, 2) == 0);
        flush = !m_done && ($urandom_range(0, 39) == 0);
        step();
        guard++;
      end
      stall = 1'b0;
      flush = 1'b0;
      if (guard >= 100) chk("rand_drain", 1'b1, 1'b0);
    end
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
